// File: rtl/acople_in_param.sv
// acople_in_param: multi-channel input coupling stage.
// Each channel sample (IW-bit two's complement) is sign-extended, shifted left
// by FRAC_SH and clamped to a signed W-bit range. A per-channel flag records
// whether the value was clamped. A single valid/ready register stage drives the
// outputs.
// Optional feature: define ACOPLE_AVG_EN to average 2^AVG_LOG2 consecutive
// accepted sample sets per output (block average, arithmetic floor).
module acople_in_param #(
   parameter int IW       = 8,
   parameter int W        = 19,
   parameter int FRAC_SH  = 0,
   parameter int NCH      = 2,
   parameter int AVG_LOG2 = 2
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              Clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NCH*IW-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NCH*W-1:0]  out_data,
   output logic [NCH-1:0]    sat_flag
);

   localparam int XW = W + FRAC_SH;

   // Reject parameter sets the datapath cannot represent.
   if (W < IW || NCH < 1 || NCH > 8 || AVG_LOG2 < 1 || AVG_LOG2 > 4 || FRAC_SH < 0) begin : g_bad_param
      $error("acople_in_param: illegal parameter combination");
   end

   // Returns {saturated, value}: sign-extend, shift, clamp to signed W bits.
   // The value fits when every bit from the W-1 position upward equals the sign.
   function automatic logic [W:0] convert(input logic [IW-1:0] x);
      logic signed [XW-1:0] shifted;
      logic [FRAC_SH:0]     upper;
      logic [W:0]           res;
      shifted = XW'(signed'(x)) <<< FRAC_SH;
      upper   = shifted[XW-1:W-1];
      if (upper == '0 || upper == '1)
         res = {1'b0, shifted[W-1:0]};
      else if (shifted[XW-1])
         res = {1'b1, 1'b1, {(W-1){1'b0}}};
      else
         res = {1'b1, 1'b0, {(W-1){1'b1}}};
      return res;
   endfunction

   logic [IW-1:0]    src [NCH];
   logic [NCH*W-1:0] conv_data;
   logic [NCH-1:0]   conv_sat;
   logic             accept;
   logic             load;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Convert every channel of the selected source samples.
   always_comb begin
      logic [W:0] r;
      // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and infers a latch.
      r         = '0;
      conv_data = '0;
      conv_sat  = '0;
      for (int k = 0; k < NCH; k++) begin
         r                  = convert(src[k]);
         conv_data[k*W +: W] = r[W-1:0];
         conv_sat[k]         = r[W];
      end
   end

`ifdef ACOPLE_AVG_EN
   localparam int SW = IW + AVG_LOG2;

   typedef enum logic {ACC, OUT} state_t;

   state_t               state;
   state_t               state_nxt;
   logic signed [SW-1:0] acc [NCH];
   logic signed [SW-1:0] sum [NCH];
   logic [AVG_LOG2-1:0]  cnt;
   logic                 last;

   assign last = (cnt == '1);
   assign load = accept && (state == ACC) && last;

   // Running sum including the offered sample; its floor average is the converter source.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         sum[k] = acc[k] + SW'(signed'(in_data[k*IW +: IW]));
         src[k] = IW'(sum[k] >>> AVG_LOG2);
      end
   end

   // Next state: a completed window moves to OUT, which always returns to ACC.
   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (load) state_nxt = OUT;
         OUT:     state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
      if (Clear) state_nxt = ACC;
   end

   // State, accumulators and window counter; a finished window leaves them zeroed
   // so an accept during OUT starts the next window with that sample.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ACC;
         cnt   <= '0;
         // NOTE: the accumulator array is reset explicitly because a partial window must never survive reset.
         for (int k = 0; k < NCH; k++) acc[k] <= '0;
      end else begin
         state <= state_nxt;
         if (Clear || load) begin
            cnt <= '0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
            for (int k = 0; k < NCH; k++) acc[k] <= sum[k];
         end
      end
   end
`else
   // Pass-through: every accepted set is converted directly.
   always_comb begin
      for (int k = 0; k < NCH; k++) src[k] = in_data[k*IW +: IW];
   end

   assign load = accept;
`endif

   // Output register: Clear wins, then a new load, else a completed transfer empties it.
   always_ff @(posedge CLK or negedge Reset_n) begin
      // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
      if (!Reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= '0;
      end else if (Clear) begin
         out_valid <= 1'b0;
         sat_flag  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= conv_data;
         sat_flag  <= conv_sat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acople_in_param.sv
// Self-checking bench for acople_in_param: a default instance and a FRAC_SH=12
// instance share the same stimulus. Pass-through vectors run in the default
// build; window-averaging vectors run when ACOPLE_AVG_EN is defined.
module tb_acople_in_param;

   localparam int IW  = 8;
   localparam int W   = 19;
   localparam int NCH = 2;

   logic              CLK = 1'b0;
   logic              Reset_n;
   logic              Clear;
   logic              in_valid;
   logic              out_ready;
   logic [NCH*IW-1:0] in_data;

   logic              in_ready, out_valid;
   logic [NCH*W-1:0]  out_data;
   logic [NCH-1:0]    sat_flag;

   logic              sh_in_ready, sh_out_valid;
   logic [NCH*W-1:0]  sh_out_data;
   logic [NCH-1:0]    sh_sat_flag;

   int checks   = 0;
   int failures = 0;

   acople_in_param dut (
      .CLK(CLK), .Reset_n(Reset_n), .Clear(Clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_flag(sat_flag)
   );

   acople_in_param #(.FRAC_SH(12)) dut_sh (
      .CLK(CLK), .Reset_n(Reset_n), .Clear(Clear),
      .in_valid(in_valid), .in_ready(sh_in_ready), .in_data(in_data),
      .out_valid(sh_out_valid), .out_ready(out_ready), .out_data(sh_out_data),
      .sat_flag(sh_sat_flag)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   typedef struct {
      logic [7:0]  c0, c1;
      logic [18:0] e0, e1;
      logic [1:0]  es;
      logic [18:0] h0, h1;
      logic [1:0]  hs;
   } vec_t;

   typedef struct {
      logic [3:0][7:0] s0, s1;
      logic [18:0]     e0, e1;
      logic [1:0]      hs;
   } win_t;

   vec_t vt [5];
   win_t wt [4];

   initial begin
      // Pass-through vectors: default instance (e*) and FRAC_SH=12 instance (h*).
      vt[0] = '{c0:8'h7F, c1:8'h80, e0:19'h0007F, e1:19'h7FF80, es:2'b00, h0:19'h3FFFF, h1:19'h40000, hs:2'b11};
      vt[1] = '{c0:8'h00, c1:8'h01, e0:19'h00000, e1:19'h00001, es:2'b00, h0:19'h00000, h1:19'h01000, hs:2'b00};
      vt[2] = '{c0:8'hFF, c1:8'h40, e0:19'h7FFFF, e1:19'h00040, es:2'b00, h0:19'h7F000, h1:19'h3FFFF, hs:2'b10};
      vt[3] = '{c0:8'h3F, c1:8'hC0, e0:19'h0003F, e1:19'h7FFC0, es:2'b00, h0:19'h3F000, h1:19'h40000, hs:2'b00};
      vt[4] = '{c0:8'hC1, c1:8'h81, e0:19'h7FFC1, e1:19'h7FF81, es:2'b00, h0:19'h41000, h1:19'h40000, hs:2'b10};

      // Averaging windows: s*[j] is the j-th sample; e* is the floor average (default instance).
      wt[0].s0 = {8'd8, 8'd6, 8'd5, 8'd4};     wt[0].s1 = {8'd0, 8'd0, 8'd0, 8'd0};
      wt[0].e0 = 19'd5;                        wt[0].e1 = 19'd0;        wt[0].hs = 2'b00;
      wt[1].s0 = {8'hFE, 8'hFF, 8'hFF, 8'hFF}; wt[1].s1 = {8'h7F, 8'h7F, 8'h7F, 8'h7F};
      wt[1].e0 = 19'h7FFFE;                    wt[1].e1 = 19'h0007F;    wt[1].hs = 2'b10;
      wt[2].s0 = {8'h80, 8'h80, 8'h80, 8'h80}; wt[2].s1 = {8'd0, 8'd0, 8'd0, 8'd1};
      wt[2].e0 = 19'h7FF80;                    wt[2].e1 = 19'd0;        wt[2].hs = 2'b01;
      wt[3].s0 = {8'd0, 8'd0, 8'd0, 8'hFF};    wt[3].s1 = {8'd3, 8'd3, 8'd3, 8'd2};
      wt[3].e0 = 19'h7FFFF;                    wt[3].e1 = 19'd2;        wt[3].hs = 2'b00;

      Reset_n   = 1'b0;
      Clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;

      @(negedge CLK);
      @(negedge CLK);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset sat_flag", sat_flag, 0);
      check("reset in_ready", in_ready, 1);
      Reset_n = 1'b1;
      step();

`ifndef ACOPLE_AVG_EN
      // Back-to-back stream: one output per accepted set, latency one cycle.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = {vt[i].c1, vt[i].c0};
         step();
         check($sformatf("v%0d out_valid", i), out_valid, 1);
         check($sformatf("v%0d out_data", i), out_data, {vt[i].e1, vt[i].e0});
         check($sformatf("v%0d sat_flag", i), sat_flag, vt[i].es);
         check($sformatf("v%0d sh_out_data", i), sh_out_data, {vt[i].h1, vt[i].h0});
         check($sformatf("v%0d sh_sat_flag", i), sh_sat_flag, vt[i].hs);
      end
      in_valid = 1'b0;
      step();
      check("drain out_valid", out_valid, 0);

      // Backpressure: held output blocks input; release transfers and reloads on one edge.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {vt[1].c1, vt[1].c0};
      step();
      check("bp first out_valid", out_valid, 1);
      in_data = {vt[2].c1, vt[2].c0};
      #1;
      check("bp in_ready low", in_ready, 0);
      for (int c = 0; c < 2; c++) begin
         step();
         check($sformatf("bp hold%0d out_valid", c), out_valid, 1);
         check($sformatf("bp hold%0d out_data", c), out_data, {vt[1].e1, vt[1].e0});
         check($sformatf("bp hold%0d sh_sat_flag", c), sh_sat_flag, vt[1].hs);
      end
      out_ready = 1'b1;
      #1;
      check("bp in_ready high", in_ready, 1);
      step();
      check("bp reload out_valid", out_valid, 1);
      check("bp reload out_data", out_data, {vt[2].e1, vt[2].e0});
      check("bp reload sh_sat_flag", sh_sat_flag, vt[2].hs);
      in_valid = 1'b0;
      step();
      check("bp drain out_valid", out_valid, 0);

      // Clear with a simultaneous accept discards the sample and empties the stage.
      in_valid = 1'b1;
      in_data  = {vt[0].c1, vt[0].c0};
      step();
      check("clr pending sh_sat_flag", sh_sat_flag, 2'b11);
      in_data = {vt[3].c1, vt[3].c0};
      Clear   = 1'b1;
      step();
      check("clr out_valid", out_valid, 0);
      check("clr sat_flag sh", sh_sat_flag, 0);
      check("clr sh_out_valid", sh_out_valid, 0);
      Clear    = 1'b0;
      in_valid = 1'b0;
      step();
      check("clr after out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_data  = {vt[4].c1, vt[4].c0};
      step();
      check("clr resume out_data", out_data, {vt[4].e1, vt[4].e0});
      check("clr resume sh_sat_flag", sh_sat_flag, vt[4].hs);

      // Reset mid-operation drops the pending output at once.
      in_data = {vt[0].c1, vt[0].c0};
      step();
      in_valid = 1'b0;
      Reset_n  = 1'b0;
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst out_data", out_data, 0);
      check("rst sh_sat_flag", sh_sat_flag, 0);
      #2;
      Reset_n = 1'b1;
      step();
      check("rst after out_valid", out_valid, 0);
`else
      // Continuous windows: output only on each 4th accept, next window starts during OUT.
      for (int w = 0; w < 4; w++) begin
         for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = {wt[w].s1[j], wt[w].s0[j]};
            step();
            if (j < 3) begin
               check($sformatf("w%0d s%0d out_valid", w, j), out_valid, 0);
            end else begin
               check($sformatf("w%0d out_valid", w), out_valid, 1);
               check($sformatf("w%0d out_data", w), out_data, {wt[w].e1, wt[w].e0});
               check($sformatf("w%0d sat_flag", w), sat_flag, 0);
               check($sformatf("w%0d sh_sat_flag", w), sh_sat_flag, wt[w].hs);
            end
         end
      end
      in_valid = 1'b0;
      step();
      check("avg drain out_valid", out_valid, 0);

      // Reset after two samples of a window: partial sum is dropped.
      in_valid = 1'b1;
      in_data  = {8'd0, 8'd100};
      step();
      step();
      in_valid = 1'b0;
      Reset_n  = 1'b0;
      #1;
      check("avg rst out_valid", out_valid, 0);
      check("avg rst out_data", out_data, 0);
      #2;
      Reset_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1;
         in_data  = {8'd0, 8'd8};
         step();
         if (j < 3) check($sformatf("avg rst s%0d out_valid", j), out_valid, 0);
      end
      check("avg rst window out_valid", out_valid, 1);
      check("avg rst window out_data", out_data, {19'd0, 19'd8});

      // Clear on what would be the 4th accept: no output, window restarts.
      for (int j = 0; j < 3; j++) begin
         in_data = {8'd0, 8'd20};
         step();
      end
      Clear = 1'b1;
      step();
      check("avg clr out_valid", out_valid, 0);
      Clear = 1'b0;
      for (int j = 0; j < 4; j++) begin
         in_data = {8'd0, (j == 3) ? 8'd6 : 8'd2};
         step();
         if (j < 3) check($sformatf("avg clr s%0d out_valid", j), out_valid, 0);
      end
      check("avg clr window out_valid", out_valid, 1);
      check("avg clr window out_data", out_data, {19'd0, 19'd3});
      in_valid = 1'b0;
      step();
      check("avg clr drain out_valid", out_valid, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/acople_in_param.md
ACOPLE_IN_PARAM -- requirements
Module: acople_in_param

Interface
REQ-001 SHALL have parameter IW, default 8, input sample width in bits, two's complement.
REQ-002 SHALL have parameter W, default 19, output width in bits; W >= IW required.
REQ-003 SHALL have parameter FRAC_SH, default 0, left shift applied after sign extension.
REQ-004 SHALL have parameter NCH, default 2, number of channels; range 1..8.
REQ-005 SHALL have parameter AVG_LOG2, default 2, log2 of the averaging window; range 1..4.
REQ-006 SHALL have port CLK, input, 1 bit: single clock, all state on rising edge.
REQ-007 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port Clear, input, 1 bit: synchronous, active-high flush.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data holds a sample set.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts a sample set.
REQ-011 SHALL have port in_data, input, NCH*IW bits: channel k at bits [k*IW +: IW].
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 SHALL have port out_data, output, NCH*W bits: channel k at bits [k*W +: W].
REQ-015 SHALL have port sat_flag, output, NCH bits: channel k output was saturated.

Function
REQ-016 SHALL accept a sample set only when in_valid && in_ready.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL convert each channel as follows: sign-extend to W+FRAC_SH bits, shift left by FRAC_SH, then clamp to the signed W-bit range [-2^(W-1), 2^(W-1)-1].
REQ-019 SHALL set sat_flag[k] with the same register load as out_data when channel k was clamped, and clear it otherwise.
REQ-020 SHALL load out_data on accept, with out_valid high on the next cycle (latency 1), when averaging is compiled out.
REQ-021 SHALL hold out_data, out_valid and sat_flag stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after out_valid && out_ready, unless a new load occurs in the same cycle; in that case out_valid stays high and the new data loads.
REQ-023 SHALL make Clear take priority over an accept in the same cycle: the sample is discarded, and out_valid and sat_flag go to 0.

Reset
REQ-024 SHALL, while Reset_n is low, asynchronously force out_valid=0, out_data=0, sat_flag=0, accumulators=0, window counter=0 and FSM=ACC.
REQ-025 SHALL drop any partial window and pending output when reset is asserted mid-operation; the first accepted sample after release starts a new window.

Configuration
REQ-026 SHALL use macro ACOPLE_AVG_EN: when defined, the block includes the averaging FSM; when undefined, the FSM, accumulators and counter are absent and behaviour is REQ-020.
REQ-027 SHALL, with ACOPLE_AVG_EN defined, keep per-channel signed accumulators IW+AVG_LOG2 bits wide and an AVG_LOG2-bit window counter.
REQ-028 SHALL, with ACOPLE_AVG_EN defined, have FSM states ACC and OUT. ACC adds each accepted sample. On the 2^AVG_LOG2-th accept it goes to OUT, loading sum>>>AVG_LOG2 (arithmetic, floor) through the REQ-018 conversion into out_data.
REQ-029 SHALL, with ACOPLE_AVG_EN defined, leave OUT for ACC in one cycle, with accumulators and counter zeroed. An accept during the OUT cycle starts the next window with that sample.
REQ-030 SHALL, with ACOPLE_AVG_EN defined, zero accumulators and counter on Clear and return the FSM to ACC.

Verification
REQ-031 SHALL cover: defaults, ACOPLE_AVG_EN undefined, in_data={8'h80,8'h7F} accepted -> next cycle out_valid=1, ch0=19'h0007F, ch1=19'h7FF80, sat_flag=0.
REQ-032 SHALL cover: FRAC_SH=12, in ch0=8'h7F, ch1=8'h80 -> ch0=19'h3FFFF, ch1=19'h40000, sat_flag=2'b11.
REQ-033 SHALL cover: out_ready=0 with out_valid=1, in_valid=1 -> in_ready=0, outputs unchanged; raise out_ready -> transfer and the new load on the same edge.
REQ-034 SHALL cover: ACOPLE_AVG_EN defined, ch0 samples 4,5,6,8 -> one output ch0=19'd5; samples -1,-1,-1,-2 -> 19'h7FFFE (floor of -1.25).
REQ-035 SHALL cover: Reset_n pulsed low after 2 of 4 window samples -> outputs 0 immediately; the next four samples 8,8,8,8 -> ch0=8.
REQ-036 SHALL cover: Clear and an accept in the same cycle -> no output produced, out_valid=0, window restarts.
